multdiv_seq: RTL and testbench

- Multi-cycle signed 32-bit multiply/divide unit in the execute stage.
- Sits directly downstream of the 32-bit carry-select adder: instantiates one adder as its only add/subtract datapath and consumes its sum every iteration.
- Processor stalls on a start pulse and resumes when data_resultRDY pulses.
- One operation in flight at a time.

---
 rtl/multdiv_seq.sv | 200 ++++++++++++++++++++
 tb/tb_multdiv_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring); RDY pulses 33 cycles after a start.
// Optional MULTDIV_EARLY_DIV0_EN: a divide-by-zero start completes after 1 cycle instead of 33.

module csa_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] c;

  assign c[0] = cin;

  // 4-bit ripple blocks computed for both carry-ins, selected by the incoming carry
  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign s1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
    assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
    assign c[g+1]        = c[g] ? s1[4]   : s0[4];
  end

  assign cout = c[8];
endmodule

module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic             q_1;
  logic             sgn_neg;
  logic             div_zero;
  logic             div_ovf;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cin;
  logic             add_cout;

  logic             start;
  logic             start_div;
  logic [WIDTH-1:0] div_shift;
  logic             booth_sign;
  logic [WIDTH:0]   mul_top;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign div_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign mul_top   = {hi, lo[WIDTH-1]};

  // True sign of the 33-bit Booth partial sum; acc - (-2^31) overflows 32 bits
  assign booth_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

  csa_adder32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The start cycle borrows the adder to take |dividend|; anything in flight is aborted anyway
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (start_div) begin
      add_b   = ~data_operandA;
      add_cin = 1'b1;
    end else if (!start) begin
      case (state)
        MUL: begin
          add_a = hi;
          case ({lo[0], q_1})
            2'b01: add_b = opnd;
            2'b10: begin
              add_b   = ~opnd;
              add_cin = 1'b1;
            end
            default: ;
          endcase
        end
        DIV: begin
          // Subtracting |divisor| equals adding a negative divisor as-is
          add_a = div_shift;
          if (opnd[WIDTH-1]) begin
            add_b = opnd;
          end else begin
            add_b   = ~opnd;
            add_cin = 1'b1;
          end
        end
        FIX: begin
          add_b   = ~lo;
          add_cin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      op_div         <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      opnd           <= '0;
      q_1            <= 1'b0;
      sgn_neg        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        cnt      <= '0;
        hi       <= '0;
        q_1      <= 1'b0;
        sgn_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        if (ctrl_MULT) begin
          state  <= MUL;
          op_div <= 1'b0;
          opnd   <= data_operandA;
          lo     <= data_operandB;
        end else begin
          op_div <= 1'b1;
          opnd   <= data_operandB;
          lo     <= data_operandA[WIDTH-1] ? add_sum : data_operandA;
`ifdef MULTDIV_EARLY_DIV0_EN
          state  <= (data_operandB == '0) ? FIX : DIV;
`else
          state  <= DIV;
`endif
        end
      end else begin
        case (state)
          MUL: begin
            {hi, lo, q_1} <= {booth_sign, add_sum, lo};
            cnt           <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
          DIV: begin
            hi  <= add_cout ? add_sum : div_shift;
            lo  <= {lo[WIDTH-2:0], add_cout};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
          FIX: begin
            state          <= IDLE;
            data_resultRDY <= 1'b1;
            if (!op_div) begin
              data_result    <= lo;
              data_exception <= !((&mul_top) || !(|mul_top));
            end else if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
            end else if (div_ovf) begin
              data_result    <= MIN_NEG;
              data_exception <= 1'b1;
            end else begin
              data_result    <= sgn_neg ? add_sum : lo;
              data_exception <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed and random checks of multdiv_seq against an arithmetic reference model.
module tb_multdiv_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic
  task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat);
    int     sa;
    int     sb;
    longint p;
    sa  = a;
    sb  = b;
    lat = 33;
    if (is_mul) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      r = 32'h0;
      e = 1'b1;
`ifdef MULTDIV_EARLY_DIV0_EN
      lat = 1;
`endif
    end else if (a == 32'h80000000 && sb == -1) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endtask

  // mode: 0 multiply, 1 divide, 2 both pulses; start edge E occurs inside
  task automatic issue(input int mode, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = (mode != 1);
    ctrl_DIV      = (mode != 0);
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string tag, input int exp_lat,
                          input logic [31:0] exp_r, input logic exp_e);
    int n;
    for (n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) break;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".res"}, data_result, exp_r);
    chk({tag, ".exc"}, {31'b0, data_exception}, {31'b0, exp_e});
    @(posedge clock); #1;
    chk({tag, ".rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
    chk({tag, ".hold"}, data_result, exp_r);
  endtask

  task automatic run(input string tag, input int mode, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          lat;
    model(mode != 1, a, b, r, e, lat);
    issue(mode, a, b);
    wait_rdy(tag, lat, r, e);
  endtask

  function automatic logic [31:0] rnd();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00010000};
    case ($urandom_range(0, 5))
      0:       return corners[$urandom_range(0, 5)];
      1:       return 32'(int'($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.res", data_result, 32'h0);
    chk("reset.exc", {31'b0, data_exception}, 32'h0);
    chk("reset.rdy", {31'b0, data_resultRDY}, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    run("mul_7x-6", 0, 32'd7, 32'hFFFFFFFA);
    chk("mul_7x-6.const", data_result, 32'hFFFFFFD6);
    run("mul_ovf", 0, 32'h00010000, 32'h00010000);
    chk("mul_ovf.const_exc", {31'b0, data_exception}, 32'd1);
    run("mul_min_x1", 0, 32'h80000000, 32'h1);
    chk("mul_min_x1.const", data_result, 32'h80000000);
    run("div_-7/2", 1, 32'hFFFFFFF9, 32'd2);
    chk("div_-7/2.const", data_result, 32'hFFFFFFFD);
    run("div_100/-10", 1, 32'd100, 32'hFFFFFFF6);
    chk("div_100/-10.const", data_result, 32'hFFFFFFF6);
    run("div_5/0", 1, 32'd5, 32'h0);
    run("div_min/-1", 1, 32'h80000000, 32'hFFFFFFFF);
    run("both_4_2", 2, 32'd4, 32'd2);
    chk("both_4_2.const", data_result, 32'd8);

    // Abort: multiply at E, divide restarts at E+10, single RDY after E+43
    issue(0, 32'd3, 32'd3);
    seen = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen = 1'b1;
    end
    chk("abort.no_rdy", {31'b0, seen}, 32'd0);
    issue(1, 32'd9, 32'd3);
    wait_rdy("abort", 33, 32'd3, 1'b0);

    // Reset at E+20 discards the operation; a start during reset is ignored
    issue(0, 32'd3, 32'd3);
    repeat (19) begin
      @(posedge clock); #1;
    end
    reset     = 1'b1;
    ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    reset     = 1'b0;
    chk("rst_mid.res", data_result, 32'h0);
    chk("rst_mid.exc", {31'b0, data_exception}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen = 1'b1;
    end
    chk("rst_mid.no_rdy", {31'b0, seen}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      run($sformatf("rnd%0d", i), int'($urandom_range(0, 2)), rnd(), rnd());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
